// File: rtl/mem_access_unit.sv
// Memory-stage access initiator: turns an M-stage load/store into a req/ack
// transaction, stalls the pipeline meanwhile and reports misalignment/timeout.
module mem_access_unit #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        M_op,
    input  logic [31:0]       M_valE,
    input  logic [31:0]       M_valA,
    output logic [31:0]       m_valM,
    output logic              m_stall,
    output logic [1:0]        m_exc,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata
);

    // MIPS lw/sw opcodes
    localparam logic [5:0] ILW = 6'b100011;
    localparam logic [5:0] ISW = 6'b101011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]        state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [1:0]        exc_reg, exc_next;
    logic [31:0]       valm_reg, valm_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;

    logic is_mem;
    logic misaligned;
    logic unused_bits;

    assign is_mem      = (M_op == ILW) || (M_op == ISW);
    assign misaligned  = (M_valE[1:0] != 2'b00);
    // Upper address bits lie outside the word-indexed memory.
    assign unused_bits = ^M_valE[31:ADDR_W+2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        exc_next   = exc_reg;
        valm_next  = valm_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (is_mem) begin
                    if (misaligned) begin
                        exc_next   = EXC_MISALIGN;
                        state_next = DONE;
                    end else begin
                        we_next    = (M_op == ISW);
                        addr_next  = M_valE[ADDR_W+1:2];
                        wdata_next = M_valA;
                        cnt_next   = 8'd1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // Ack is checked first so a late ack still wins over the abort.
                if (dm_ack) begin
                    if (!we_reg) begin
                        valm_next = dm_rdata;
                    end
                    exc_next   = EXC_NONE;
                    state_next = DONE;
                end else if (cnt_reg >= TIMEOUT_CNT) begin
                    exc_next   = EXC_TIMEOUT;
                    state_next = DONE;
                end else if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            exc_reg   <= EXC_NONE;
            valm_reg  <= 32'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            exc_reg   <= exc_next;
            valm_reg  <= valm_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Request and stall derive from state so a reset drops them immediately.
    assign dm_req   = (state_reg == BUSY);
    assign m_stall  = ((state_reg == IDLE) && is_mem) || (state_reg == BUSY);
    assign m_exc    = (state_reg == DONE) ? exc_reg : EXC_NONE;
    assign m_valM   = valm_reg;
    assign dm_we    = we_reg;
    assign dm_addr  = addr_reg;
    assign dm_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: one task per scenario, inputs driven
// on the falling edge and outputs checked 1 time unit later.
module tb_mem_access_unit;

    localparam logic [5:0] ILW = 6'b100011;
    localparam logic [5:0] ISW = 6'b101011;
    localparam logic [5:0] NOP = 6'b000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  M_op;
    logic [31:0] M_valE, M_valA;
    logic [31:0] m_valM;
    logic        m_stall;
    logic [1:0]  m_exc;
    logic        dm_req, dm_we;
    logic [5:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_access_unit #(.ADDR_W(6), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .M_op(M_op), .M_valE(M_valE), .M_valA(M_valA),
        .m_valM(m_valM), .m_stall(m_stall), .m_exc(m_exc),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge; stimulus for that cycle follows.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; M_op = NOP; M_valE = 0; M_valA = 0; dm_ack = 0; dm_rdata = 0;
        next_cycle(); #1;
        total_cnt++; if (m_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", m_stall); else pass_cnt++;
        total_cnt++; if ({dm_req, dm_we, dm_addr, dm_wdata, m_valM, m_exc} !== 72'd0)
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h valM=%h exc=%b want all 0",
                     dm_req, dm_we, dm_addr, dm_wdata, m_valM, m_exc);
        else pass_cnt++;
        next_cycle(); rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_load();
        next_cycle(); M_op = ILW; M_valE = 32'h10; #1;
        total_cnt++; if ({m_stall, dm_req} !== 2'b10) $display("FAIL load_idle: got stall=%b req=%b want 1 0", m_stall, dm_req); else pass_cnt++;
        next_cycle(); dm_ack = 1; dm_rdata = 32'hDEADBEEF; #1;
        total_cnt++; if ({m_stall, dm_req, dm_we, dm_addr} !== {1'b1, 1'b1, 1'b0, 6'd4})
            $display("FAIL load_busy: got stall=%b req=%b we=%b addr=%0d want 1 1 0 4", m_stall, dm_req, dm_we, dm_addr);
        else pass_cnt++;
        next_cycle(); dm_ack = 0; dm_rdata = 0; #1;
        total_cnt++; if ({m_stall, dm_req, m_exc} !== 4'b0000) $display("FAIL load_done_ctl: got stall=%b req=%b exc=%b want 0 0 00", m_stall, dm_req, m_exc); else pass_cnt++;
        total_cnt++; if (m_valM !== 32'hDEADBEEF) $display("FAIL load_data: got %h want deadbeef", m_valM); else pass_cnt++;
        next_cycle(); M_op = NOP; #1;
        total_cnt++; if (m_stall !== 1'b0) $display("FAIL load_after: got stall=%b want 0", m_stall); else pass_cnt++;
        $display("load 0x10 -> %h", m_valM);
    endtask

    task automatic test_store();
        int stall_cycles = 0;
        next_cycle(); M_op = ISW; M_valE = 32'h20; M_valA = 32'h12345678; #1;
        if (m_stall) stall_cycles++;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); M_valA = 32'hFFFF0000 + i; dm_ack = (i == 2); #1;
            if (m_stall) stall_cycles++;
            total_cnt++; if ({dm_req, dm_we, dm_addr, dm_wdata} !== {1'b1, 1'b1, 6'd8, 32'h12345678})
                $display("FAIL store_busy%0d: got req=%b we=%b addr=%0d wdata=%h want 1 1 8 12345678", i, dm_req, dm_we, dm_addr, dm_wdata);
            else pass_cnt++;
        end
        next_cycle(); dm_ack = 0; #1;
        total_cnt++; if ({m_stall, dm_req, m_exc} !== 4'b0000) $display("FAIL store_done: got stall=%b req=%b exc=%b want 0 0 00", m_stall, dm_req, m_exc); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4) $display("FAIL store_stall_len: got %0d want 4", stall_cycles); else pass_cnt++;
        total_cnt++; if (m_valM !== 32'hDEADBEEF) $display("FAIL store_valM: got %h want deadbeef", m_valM); else pass_cnt++;
        next_cycle(); M_op = NOP; #1;
        $display("store 0x20 <- 12345678, stall %0d cycles", stall_cycles);
    endtask

    task automatic test_misaligned();
        next_cycle(); M_op = ILW; M_valE = 32'h13; #1;
        total_cnt++; if ({m_stall, dm_req, m_exc} !== 4'b1000) $display("FAIL mis_idle: got stall=%b req=%b exc=%b want 1 0 00", m_stall, dm_req, m_exc); else pass_cnt++;
        next_cycle(); #1;
        total_cnt++; if ({m_stall, dm_req, m_exc} !== 4'b0001) $display("FAIL mis_done: got stall=%b req=%b exc=%b want 0 0 01", m_stall, dm_req, m_exc); else pass_cnt++;
        next_cycle(); M_op = NOP; #1;
        total_cnt++; if ({m_stall, dm_req, m_exc} !== 4'b0000) $display("FAIL mis_after: got stall=%b req=%b exc=%b want 0 0 00", m_stall, dm_req, m_exc); else pass_cnt++;
        $display("misaligned load 0x13 flagged");
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        next_cycle(); M_op = ILW; M_valE = 32'h0; dm_rdata = 32'hBAD0BAD0; #1;
        for (int i = 0; i < 40 && !(i > 0 && !dm_req); i++) begin
            next_cycle(); #1;
            if (dm_req) req_cycles++;
        end
        total_cnt++; if (req_cycles !== 15) $display("FAIL timeout_req_len: got %0d want 15", req_cycles); else pass_cnt++;
        total_cnt++; if ({m_stall, m_exc} !== 3'b010) $display("FAIL timeout_done: got stall=%b exc=%b want 0 10", m_stall, m_exc); else pass_cnt++;
        total_cnt++; if (m_valM !== 32'hDEADBEEF) $display("FAIL timeout_valM: got %h want deadbeef", m_valM); else pass_cnt++;
        next_cycle(); M_op = NOP; dm_rdata = 0; #1;
        $display("load 0x0 timed out after %0d request cycles", req_cycles);
    endtask

    task automatic test_late_ack();
        next_cycle(); M_op = ILW; M_valE = 32'h3C; #1;
        for (int i = 1; i <= 15; i++) begin
            next_cycle(); dm_ack = (i == 15); dm_rdata = (i == 15) ? 32'hCAFEF00D : 32'h0; #1;
        end
        total_cnt++; if (dm_req !== 1'b1) $display("FAIL late_ack_req: got %b want 1", dm_req); else pass_cnt++;
        next_cycle(); dm_ack = 0; dm_rdata = 0; #1;
        total_cnt++; if ({m_exc, m_valM} !== {2'b00, 32'hCAFEF00D}) $display("FAIL late_ack_done: got exc=%b valM=%h want 00 cafef00d", m_exc, m_valM); else pass_cnt++;
        next_cycle(); M_op = NOP; #1;
        $display("load 0x3c acked in 15th busy cycle -> %h", m_valM);
    endtask

    task automatic test_back_to_back();
        // Stray ack while idle must be ignored.
        next_cycle(); dm_ack = 1; dm_rdata = 32'h11111111; #1;
        total_cnt++; if ({m_stall, dm_req, m_valM} !== {2'b00, 32'hCAFEF00D}) $display("FAIL idle_ack: got stall=%b req=%b valM=%h want 0 0 cafef00d", m_stall, dm_req, m_valM); else pass_cnt++;
        next_cycle(); M_op = ILW; M_valE = 32'h4; dm_ack = 0; #1;
        next_cycle(); dm_ack = 1; dm_rdata = 32'hAAAA0001; #1;
        next_cycle(); dm_ack = 0; #1;
        total_cnt++; if (m_valM !== 32'hAAAA0001) $display("FAIL b2b_first: got %h want aaaa0001", m_valM); else pass_cnt++;
        next_cycle(); M_valE = 32'h8; #1;
        total_cnt++; if ({m_stall, dm_req} !== 2'b10) $display("FAIL b2b_second_idle: got stall=%b req=%b want 1 0", m_stall, dm_req); else pass_cnt++;
        next_cycle(); dm_ack = 1; dm_rdata = 32'h00000055; #1;
        total_cnt++; if (dm_addr !== 6'd2) $display("FAIL b2b_addr: got %0d want 2", dm_addr); else pass_cnt++;
        next_cycle(); dm_ack = 0; M_op = NOP; #1;
        total_cnt++; if (m_valM !== 32'h00000055) $display("FAIL b2b_second: got %h want 00000055", m_valM); else pass_cnt++;
        $display("back-to-back loads 0x4, 0x8 -> %h", m_valM);
    endtask

    task automatic test_reset_mid();
        next_cycle(); M_op = ILW; M_valE = 32'h4; #1;
        next_cycle(); #1;
        next_cycle(); M_op = NOP; #1;
        total_cnt++; if (dm_req !== 1'b1) $display("FAIL rstmid_busy: got req=%b want 1", dm_req); else pass_cnt++;
        rst_n = 1'b0; #1;
        total_cnt++; if ({dm_req, m_stall, dm_we, dm_addr, dm_wdata, m_valM, m_exc} !== 73'd0)
            $display("FAIL rstmid_outputs: got req=%b stall=%b addr=%h valM=%h exc=%b want all 0", dm_req, m_stall, dm_addr, m_valM, m_exc);
        else pass_cnt++;
        next_cycle(); rst_n = 1'b1; #1;
        next_cycle(); #1;
        total_cnt++; if ({m_stall, dm_req} !== 2'b00) $display("FAIL rstmid_idle: got stall=%b req=%b want 0 0", m_stall, dm_req); else pass_cnt++;
        $display("reset during busy abandoned access");
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_late_ack();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access initiator for the pipelined MIPS core. It converts the M-stage load/store (`M_op`, `M_valE`, `M_valA`) into a req/ack transaction toward a variable-latency data memory. It stalls the pipeline until the access completes and returns load data on `m_valM`. It also flags misaligned addresses and unresponsive memory.

## Interface
Parameters:
- `ADDR_W`, 6: word-index width of `dm_addr` (64-word memory).
- `TIMEOUT`, 15: maximum BUSY cycles without `dm_ack` before abort; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `M_op` in 6: M-stage opcode; `ILW`/`ISW` from def.v are memory ops, all other values are non-memory ops.
- `M_valE` in 32: byte address.
- `M_valA` in 32: store data.
- `m_valM` out 32: load result register.
- `m_stall` out 1: holds the pipeline while asserted.
- `m_exc` out 2: 00 none, 01 misaligned, 10 timeout.
- `dm_req` out 1: request to memory.
- `dm_we` out 1: 1 = write, 0 = read.
- `dm_addr` out ADDR_W: word index, equal to `M_valE[ADDR_W+1:2]`.
- `dm_wdata` out 32: write data.
- `dm_ack` in 1: memory completion; sampled only while `dm_req` = 1.
- `dm_rdata` in 32: read data; valid in the `dm_ack` cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, non-memory op:
  - `m_stall` = 0, no state change.
- IDLE, memory op:
  - `m_stall` = 1 (combinational) for that cycle.
  - Misaligned (`M_valE[1:0]` != 0): go to DONE with exc = 01. No request is issued.
  - Aligned: latch `dm_we` (1 for `ISW`), `dm_addr`, and `dm_wdata` = `M_valA`; clear the counter to 1; go to BUSY.
- BUSY:
  - `dm_req` = 1, `m_stall` = 1.
  - `dm_addr`, `dm_we` and `dm_wdata` stay stable for the whole BUSY period.
  - `dm_ack` = 1: for a load, capture `dm_rdata` into `m_valM`; exc = 00; go to DONE.
  - No ack and counter == `TIMEOUT`: exc = 10; go to DONE. `m_valM` is unchanged.
  - Otherwise increment the counter.
  - Ack takes priority over timeout in the same cycle.
- DONE:
  - `dm_req` = 0, `m_stall` = 0.
  - `m_exc` is driven with the latched code.
  - The pipeline advances at the end of this cycle. Next state is IDLE unconditionally.
- `m_exc` is 00 in every state except DONE.
- `m_valM` holds the last completed load value until the next successful load. Stores and aborted loads never modify it.
- `dm_ack` while `dm_req` = 0 is ignored. The counter is 8 bits wide and saturates.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; `m_valM` = 0, `m_exc` = 0, `dm_req` = 0, `dm_we` = 0, `dm_addr` = 0, `dm_wdata` = 0; counter = 0.
  - `m_stall` then follows the IDLE rule.
- Minimum memory-op latency is 3 cycles (IDLE, BUSY with ack, DONE). Each extra memory wait cycle adds 1.
- Load data appears on `m_valM` at the start of the DONE cycle.
- Misaligned op: 2 cycles (IDLE, DONE).
- Timeout: IDLE + `TIMEOUT` BUSY cycles + DONE. An ack in the `TIMEOUT`-th BUSY cycle is accepted.
- Back-to-back memory ops: the next op is seen in the cycle after DONE. No request is issued in DONE.
- Reset mid-transaction:
  - `dm_req` drops asynchronously and the access is abandoned.
  - The memory side must discard a request whose `dm_req` fell before ack.

## Test plan
- Reset, then `M_op`=`ILW`, `M_valE`=0x10, memory acks in the first BUSY cycle with `dm_rdata`=0xDEADBEEF. Required response:
  - `dm_addr`=4, `dm_we`=0.
  - `m_stall`=1,1,0 over 3 cycles; `m_valM`=0xDEADBEEF in DONE; `m_exc`=00.
- `ISW` at 0x20 with `M_valA`=0x12345678, ack after 3 BUSY cycles. Required response:
  - `dm_req` high for 3 cycles with `dm_addr`=8, `dm_we`=1, `dm_wdata`=0x12345678 constant.
  - Stall lasts 4 cycles; `m_valM` is unchanged.
- `ILW` at 0x13. Required response:
  - No `dm_req`.
  - `m_stall`=1 then 0; `m_exc`=01 in the DONE cycle only.
- `ILW` at 0x0 with memory never acking, `TIMEOUT`=15. Required response:
  - `dm_req` high exactly 15 cycles.
  - DONE with `m_exc`=10; `m_valM` keeps its previous value.
- Ack in the 15th BUSY cycle (`TIMEOUT`=15). Required response:
  - Load completes with `m_exc`=00 (ack wins over timeout).
- `rst_n` pulled low in the 2nd BUSY cycle. Required response:
  - `dm_req` and all outputs go to 0 immediately.
  - After release the FSM is in IDLE; a non-memory `M_op` gives `m_stall`=0.
